// File: rtl/riscv_ram_1rw_ctrl.sv
`timescale 1ns/1ps
// Initiator-side controller for a generic 1RW RAM: turns a valid/ready request
// stream into RAM cycles, buffers read data in a 2-entry FIFO, and runs a fill sweep.
//
// state  | meaning
// S_INIT | fill sweep: write INIT_VALUE to every word, requests blocked
// S_RUN  | accepted requests drive the RAM port directly
module riscv_ram_1rw_ctrl #(
  parameter int               ABITS       = 10,
  parameter int               DBITS       = 32,
  parameter bit               INIT_ENABLE = 1'b1,
  parameter logic [DBITS-1:0] INIT_VALUE  = '0,
  localparam int              BBITS       = (DBITS + 7) / 8
) (
  input  logic             rst_ni,
  input  logic             clk_i,
  input  logic             clear_i,
  output logic             init_done_o,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [BBITS-1:0] req_be_i,
  input  logic [DBITS-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DBITS-1:0] rsp_rdata_o,
  output logic [ABITS-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic [BBITS-1:0] ram_be_o,
  output logic [DBITS-1:0] ram_din_o,
  input  logic [DBITS-1:0] ram_dout_i
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ABITS-1:0] CNT_LAST = '1;

  state_t           state, state_next;
  logic [ABITS-1:0] cnt, cnt_next;
  logic             inflight;
  logic             head_valid, tail_valid;
  logic [DBITS-1:0] head_data, tail_data;
  logic             accept, push, pop;
  logic [1:0]       occ, credit;

  // Credit counts buffered plus in-flight reads, minus the one leaving this
  // cycle; this gives a combinational rsp_ready_i -> req_ready_o path.
  assign occ         = {1'b0, head_valid} + {1'b0, tail_valid};
  assign push        = inflight;
  assign pop         = head_valid && rsp_ready_i;
  assign credit      = occ + {1'b0, inflight} - {1'b0, pop};
  assign req_ready_o = (state == S_RUN) && (credit < 2'd2);
  assign accept      = req_valid_i && req_ready_o;
  assign init_done_o = (state == S_RUN);
  assign rsp_valid_o = head_valid;
  assign rsp_rdata_o = head_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= INIT_ENABLE ? S_INIT : S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ram_addr_o = req_addr_i;
    ram_we_o   = 1'b0;
    ram_be_o   = req_be_i;
    ram_din_o  = req_wdata_i;
    case (state)
      S_INIT: begin
        ram_addr_o = cnt;
        ram_we_o   = 1'b1;
        ram_be_o   = '1;
        ram_din_o  = INIT_VALUE;
        cnt_next   = cnt + 1'b1;
        if (cnt == CNT_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        ram_we_o = accept && req_we_i;
        if (clear_i) state_next = S_INIT;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight <= 1'b0;
    else         inflight <= accept && !req_we_i;
  end

  // Head register is the output; tail only fills when the head is occupied.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
    end else if (pop) begin
      if (tail_valid) begin
        head_data  <= tail_data;
        tail_valid <= push;
        if (push) tail_data <= ram_dout_i;
      end else if (push) begin
        head_data <= ram_dout_i;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (push) begin
      if (!head_valid) begin
        head_valid <= 1'b1;
        head_data  <= ram_dout_i;
      end else begin
        tail_valid <= 1'b1;
        tail_data  <= ram_dout_i;
      end
    end
  end

  overflow_check: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(push && !pop && tail_valid));

endmodule

// File: tb/tb_riscv_ram_1rw_ctrl.sv
`timescale 1ns/1ps
// Bench for riscv_ram_1rw_ctrl: behavioural RAM, transaction-level reference
// model (memory image + pending-read queue), directed and random phases.
module tb_riscv_ram_1rw_ctrl;
  localparam int          ABITS    = 4;
  localparam int          DBITS    = 32;
  localparam int          BBITS    = 4;
  localparam int          WORDS    = 16;
  localparam logic [31:0] INIT_VAL = 32'h5A5A_C3C3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             init_done;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [ABITS-1:0] req_addr = '0;
  logic [BBITS-1:0] req_be = '0;
  logic [DBITS-1:0] req_wdata = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [DBITS-1:0] rsp_rdata;
  logic [ABITS-1:0] ram_addr;
  logic             ram_we;
  logic [BBITS-1:0] ram_be;
  logic [DBITS-1:0] ram_din;
  logic [DBITS-1:0] ram_dout;

  riscv_ram_1rw_ctrl #(.ABITS(ABITS), .DBITS(DBITS), .INIT_ENABLE(1'b1), .INIT_VALUE(INIT_VAL)) dut (
    .rst_ni(rst_n), .clk_i(clk), .clear_i(clear), .init_done_o(init_done),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [WORDS];
  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < BBITS; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    ram_dout <= ram[ram_addr];
  end

  // Reference model: memory image, reads in flight with their accept cycle.
  logic [31:0] model_mem [WORDS];
  logic [31:0] pend_data [$];
  int          pend_cyc [$];
  bit          model_run;
  int          sweep_left;
  int          cyc = 0;
  bit          last_accept, last_ready;
  int          last_wait;
  int          vectors = 0;
  int          miscompares = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_data.delete();
    pend_cyc.delete();
    model_run  = 1'b0;
    sweep_left = WORDS;
    foreach (model_mem[i]) model_mem[i] = INIT_VAL;
  endtask

  // One clock: inputs are already driven; check, advance the model, step.
  task automatic cycle();
    bit exp_valid, pop, exp_ready, acc;
    #1;
    exp_valid = (pend_data.size() > 0) && (cyc >= pend_cyc[0] + 2);
    chk("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) chk("rsp_rdata", rsp_rdata, pend_data[0]);
    pop       = exp_valid && rsp_ready;
    exp_ready = model_run && ((pend_data.size() - (pop ? 1 : 0)) < 2);
    chk("req_ready", req_ready, exp_ready);
    chk("init_done", init_done, model_run);
    acc = req_valid && exp_ready;
    if (!model_run) begin
      chk("sweep_we", ram_we, 1);
      chk("sweep_addr", ram_addr, 64'(WORDS - sweep_left));
      chk("sweep_be", ram_be, 4'hF);
      chk("sweep_din", ram_din, INIT_VAL);
    end else begin
      chk("ram_we", ram_we, acc && req_we);
      if (acc) chk("ram_addr", ram_addr, req_addr);
    end
    if (pop) begin
      void'(pend_data.pop_front());
      void'(pend_cyc.pop_front());
    end
    if (acc) begin
      if (req_we) begin
        for (int b = 0; b < BBITS; b++)
          if (req_be[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end else begin
        pend_data.push_back(model_mem[req_addr]);
        pend_cyc.push_back(cyc);
      end
    end
    if (!model_run) begin
      sweep_left--;
      if (sweep_left == 0) model_run = 1'b1;
    end else if (clear) begin
      model_run  = 1'b0;
      sweep_left = WORDS;
      foreach (model_mem[i]) model_mem[i] = INIT_VAL;
    end
    last_accept = acc;
    last_ready  = req_ready;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_req(input bit we, input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = d;
    do begin
      cycle();
      n++;
    end while (!last_accept && n < 64);
    chk("req_accept_timeout", last_accept, 1);
    last_wait = n;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((pend_data.size() > 0 || !model_run) && n < 80) begin
      cycle();
      n++;
    end
    cycle();
    chk("drain_idle", rsp_valid, 0);
  endtask

  initial begin
    int idx, lowcnt, n;
    logic [3:0] rd_list [4];
    rd_list[0] = 4'd1; rd_list[1] = 4'd2; rd_list[2] = 4'd3; rd_list[3] = 4'd4;

    // Reset, sweep of 16 words, then init_done on the 17th cycle.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_init_done", init_done, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_req_ready", req_ready, 0);
    rst_n = 1'b1;
    model_reset();
    repeat (WORDS) cycle();
    chk("init_done_cycle17", init_done, 1);
    rsp_ready = 1'b1;
    for (int a = 0; a < WORDS; a++) do_req(1'b0, 4'(a), 4'h0, 32'h0);
    drain();

    // Partial write merges into earlier full write.
    do_req(1'b1, 4'd5, 4'hF, 32'hDEAD_BEEF);
    do_req(1'b1, 4'd5, 4'h1, 32'h0000_00AA);
    do_req(1'b0, 4'd5, 4'h0, 32'h0);
    cycle();
    chk("rmw_valid", rsp_valid, 1);
    chk("rmw_data", rsp_rdata, 32'hDEAD_BEAA);
    drain();
    for (int a = 1; a <= 4; a++) do_req(1'b1, 4'(a), 4'hF, 32'h1111_1111 * a);

    // Back-to-back reads with consumer ready: no stall.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, rd_list[i], 4'h0, 32'h0);
      chk("b2b_no_stall", last_wait, 1);
    end
    drain();

    // Same reads with consumer stalled: credit limit of two.
    rsp_ready = 1'b0;
    idx = 0;
    req_valid = 1'b1; req_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_addr = rd_list[idx];
      cycle();
      if (last_accept) idx++;
    end
    chk("stall_accepts", idx, 2);
    chk("stall_head", rsp_rdata, 32'h1111_1111);
    rsp_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 32) begin
      req_addr = rd_list[idx];
      cycle();
      if (last_accept) idx++;
      n++;
    end
    chk("stall_all_accepted", idx, 4);
    drain();

    // Clear with two buffered responses.
    rsp_ready = 1'b0;
    do_req(1'b0, 4'd2, 4'h0, 32'h0);
    do_req(1'b0, 4'd3, 4'h0, 32'h0);
    cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    rsp_ready = 1'b1;
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!last_ready) lowcnt++;
    end
    chk("clear_ready_low", lowcnt, WORDS);
    for (int a = 0; a < WORDS; a++) do_req(1'b0, 4'(a), 4'h0, 32'h0);
    drain();

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = 4'($urandom_range(0, WORDS - 1));
      req_be    = 4'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clear = 1'b0;
    drain();

    // Asynchronous reset mid-sweep at counter 7 with responses buffered.
    rsp_ready = 1'b0;
    do_req(1'b0, 4'd3, 4'h0, 32'h0);
    do_req(1'b0, 4'd6, 4'h0, 32'h0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    n = 0;
    while ((WORDS - sweep_left) != 7 && n < 40) begin
      cycle();
      n++;
    end
    chk("sweep_at_7", ram_addr, 7);
    chk("pre_reset_buffered", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_init_done", init_done, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_rsp_rdata", rsp_rdata, 0);
    chk("async_rst_ram_addr", ram_addr, 0);
    chk("async_rst_ram_we", ram_we, 1);
    chk("async_rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    chk("held_rst_ram_addr", ram_addr, 0);
    rst_n = 1'b1;
    model_reset();
    repeat (WORDS) cycle();
    chk("resweep_done", init_done, 1);
    rsp_ready = 1'b1;
    do_req(1'b0, 4'd6, 4'h0, 32'h0);
    do_req(1'b0, 4'd15, 4'h0, 32'h0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
